// File: rtl/pkt_serial_tx_pkg.sv
// pkt_pkg: packet width, packet type and tx sequencer states shared
// by the packet FIFO, the serial drain stage and upstream stages.
package pkt_pkg;

  localparam int PKT_W = 10;

  typedef logic [PKT_W-1:0] pkt_t;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

endpackage

// File: rtl/pkt_serial_tx_if.sv
// pkt_serial_tx_if: FIFO read port (data, empty, re).
// master = FIFO consumer (drives re); slave = FIFO (drives data, empty).
interface pkt_serial_tx_if;
  import pkt_pkg::*;

  pkt_t data;
  logic empty;
  logic re;

  modport master (
    input  data,
    input  empty,
    output re
  );

  modport slave (
    output data,
    output empty,
    input  re
  );

endinterface

// File: rtl/pkt_serial_tx_baud.sv
// pkt_baud_gen: bit-period timer. Ports: clk, rst, restart (realign
// period), bit_end (pulse in last cycle of each CLKS_PER_BIT period).
module pkt_baud_gen #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic bit_end
);

  localparam int W = $clog2(CLKS_PER_BIT);
  localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);

  logic [W-1:0] cnt;

  // Wrapping at bit_end reloads the period at every bit boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (restart || bit_end)
      cnt <= '0;
    else
      cnt <= cnt + 1'b1;
  end

  assign bit_end = (cnt == LAST);

endmodule

// File: rtl/pkt_serial_tx.sv
// pkt_serial_tx: pops packets from the FIFO and sends start/data/parity/stop.
// Ports: clk, rst, enable, fifo (read port), tx, busy, frame_done, frames_sent.
module pkt_serial_tx
  import pkt_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 1,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  pkt_serial_tx_if.master       fifo,
  output logic                  tx,
  output logic                  busy,
  output logic                  frame_done,
  output logic [15:0]           frames_sent
);

  localparam logic [3:0] LAST_DATA = 4'(PKT_W - 1);
  localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);
  localparam logic       ODD       = (PARITY_ODD != 0);

  tx_state_t  state, state_n;
  logic [3:0] bit_q, bit_n;
  pkt_t       sr, sr_n;
  logic       tx_n;
  logic       pop;
  logic       can_pop;
  logic       bit_end;

  pkt_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .rst     (rst),
    .restart (pop),
    .bit_end (bit_end)
  );

  // rst gate keeps the pop strobe low while reset is held.
  assign can_pop = enable && !fifo.empty && !rst;

  always_comb begin
    state_n    = state;
    bit_n      = bit_q;
    sr_n       = sr;
    pop        = 1'b0;
    frame_done = 1'b0;
    unique case (state)
      IDLE: begin
        if (can_pop) begin
          pop     = 1'b1;
          state_n = START;
          bit_n   = '0;
        end
      end
      START: begin
        if (bit_end) begin
          state_n = DATA;
          bit_n   = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_q == LAST_DATA) begin
            bit_n   = '0;
            state_n = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            bit_n = bit_q + 4'd1;
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_n = STOP;
          bit_n   = '0;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (bit_q == LAST_STOP) begin
            frame_done = 1'b1;
            bit_n      = '0;
            if (can_pop) begin
              pop     = 1'b1;
              state_n = START;
            end else begin
              state_n = IDLE;
            end
          end else begin
            bit_n = bit_q + 4'd1;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    if (pop)
      sr_n = fifo.data;

    // Line level is decoded from the next state so the flop
    // presents it in the first cycle of that state.
    tx_n = 1'b1;
    unique case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = sr_n[bit_n];
      PARITY:  tx_n = (^sr_n) ^ ODD;
      default: tx_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      bit_q       <= '0;
      sr          <= '0;
      tx          <= 1'b1;
      frames_sent <= '0;
    end else begin
      state <= state_n;
      bit_q <= bit_n;
      sr    <= sr_n;
      tx    <= tx_n;
      if (frame_done)
        frames_sent <= frames_sent + 16'd1;
    end
  end

  assign fifo.re = pop;
  assign busy    = (state != IDLE);

endmodule

// File: tb/tb_pkt_serial_tx.sv
// tb_pkt_serial_tx: directed bench with a frame-level line model for
// two configurations (even/1 stop and odd/2 stop, 4 clocks per bit).
module tb_pkt_serial_tx;

  localparam int CPB = 4;

  logic clk;
  logic rst;
  logic enable;

  pkt_serial_tx_if ifa();
  pkt_serial_tx_if ifb();

  logic        tx_a, busy_a, done_a;
  logic        tx_b, busy_b, done_b;
  logic [15:0] fs_a, fs_b;

  pkt_serial_tx #(
    .CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)
  ) dut_a (
    .clk(clk), .rst(rst), .enable(enable), .fifo(ifa),
    .tx(tx_a), .busy(busy_a), .frame_done(done_a), .frames_sent(fs_a)
  );

  pkt_serial_tx #(
    .CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)
  ) dut_b (
    .clk(clk), .rst(rst), .enable(enable), .fifo(ifb),
    .tx(tx_b), .busy(busy_b), .frame_done(done_b), .frames_sent(fs_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // FIFO stand-ins: pushes from the stimulus, pops on DUT fifo_re.
  logic [9:0] mem0 [16];
  logic [9:0] mem1 [16];
  int npush0 = 0, npush1 = 0;
  int npop0 = 0, npop1 = 0;

  assign ifa.empty = (npush0 == npop0);
  assign ifb.empty = (npush1 == npop1);
  assign ifa.data  = mem0[npop0 % 16];
  assign ifb.data  = mem1[npop1 % 16];

  always @(posedge clk) if (ifa.re) npop0 <= npop0 + 1;
  always @(posedge clk) if (ifb.re) npop1 <= npop1 + 1;

  // Model: words waiting, expected line level per future cycle.
  logic [9:0]  mq   [2][$];
  bit          expq [2][$];
  logic [15:0] mfs  [2];

  int nvec = 0;
  int nmis = 0;
  int cyc  = 0;

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  task automatic push(input int k, input logic [9:0] w);
    if (k == 0) begin
      mem0[npush0 % 16] = w;
      npush0++;
    end else begin
      mem1[npush1 % 16] = w;
      npush1++;
    end
    mq[k].push_back(w);
  endtask

  // Whole frame as a bit list, each bit held for CPB cycles.
  task automatic frame(input int k, input logic [9:0] w);
    bit b[$];
    b.push_back(1'b0);
    for (int i = 0; i < 10; i++) b.push_back(w[i]);
    b.push_back((^w) ^ (k == 1));
    b.push_back(1'b1);
    if (k == 1) b.push_back(1'b1);
    foreach (b[i]) repeat (CPB) expq[k].push_back(b[i]);
  endtask

  task automatic model_cmp(input int k);
    logic ef, ed, eb, et;
    logic are, adone, abusy, atx;
    logic [15:0] afs;
    are   = k ? ifb.re : ifa.re;
    adone = k ? done_b : done_a;
    abusy = k ? busy_b : busy_a;
    atx   = k ? tx_b : tx_a;
    afs   = k ? fs_b : fs_a;
    if (rst) begin
      expq[k].delete();
      mfs[k] = 16'd0;
      ef = 1'b0; ed = 1'b0; eb = 1'b0; et = 1'b1;
    end else begin
      eb = (expq[k].size() != 0);
      ed = (expq[k].size() == 1);
      et = eb ? expq[k][0] : 1'b1;
      ef = enable && (mq[k].size() != 0) && (expq[k].size() <= 1);
    end
    chk($sformatf("m%0d_fifo_re", k), 16'(are), 16'(ef));
    chk($sformatf("m%0d_frame_done", k), 16'(adone), 16'(ed));
    chk($sformatf("m%0d_busy", k), 16'(abusy), 16'(eb));
    chk($sformatf("m%0d_tx", k), 16'(atx), 16'(et));
    chk($sformatf("m%0d_frames_sent", k), afs, mfs[k]);
    if (!rst) begin
      if (eb) void'(expq[k].pop_front());
      if (ed) mfs[k] = mfs[k] + 16'd1;
      if (ef) frame(k, mq[k].pop_front());
    end
  endtask

  task automatic tick();
    @(negedge clk);
    model_cmp(0);
    model_cmp(1);
    cyc++;
  endtask

  task automatic drv();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_re(input int k, input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if ((k ? ifb.re : ifa.re) === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    chk($sformatf("pop_seen%0d", k), 16'(ok), 16'd1);
  endtask

  logic [12:0] lit1;
  int pops [4];
  int dones[4];
  logic par [4];
  int np, nd, cnt_re, cnt_x, cnt_d, stop_hi;

  initial begin
    for (int i = 0; i < 16; i++) begin
      mem0[i] = '0;
      mem1[i] = '0;
    end
    mfs[0] = 16'd0;
    mfs[1] = 16'd0;
    rst    = 1'b1;
    enable = 1'b0;
    lit1   = 13'b1_1_1010100101_0;

    repeat (2) tick();
    chk("rst_tx", 16'(tx_a), 16'd1);
    chk("rst_busy", 16'(busy_a), 16'd0);
    chk("rst_frames", fs_a, 16'd0);
    chk("rst_re", 16'(ifa.re), 16'd0);
    drv();
    rst = 1'b0;
    tick();

    // 1: single word 2A5, even parity
    drv();
    enable = 1'b1;
    push(0, 10'h2A5);
    wait_re(0, 10);
    for (int c = 1; c <= 52; c++) begin
      tick();
      if (c % 4 == 2) chk("t1_bit", 16'(tx_a), 16'(lit1[c/4]));
      if (c == 51) chk("t1_done_early", 16'(done_a), 16'd0);
      if (c == 52) chk("t1_done", 16'(done_a), 16'd1);
    end
    tick();
    chk("t1_frames", fs_a, 16'd1);
    chk("t1_idle", 16'(busy_a), 16'd0);

    // 2: empty FIFO stays idle
    cnt_re = 0;
    cnt_x  = 0;
    repeat (200) begin
      tick();
      if (ifa.re) cnt_re++;
      if (busy_a || !tx_a) cnt_x++;
    end
    chk("t2_pops", 16'(cnt_re), 16'd0);
    chk("t2_line", 16'(cnt_x), 16'd0);

    // 3: three queued words back to back
    drv();
    push(0, 10'h001);
    push(0, 10'h3FF);
    push(0, 10'h155);
    np = 0;
    nd = 0;
    for (int c = 0; c < 220; c++) begin
      tick();
      if (ifa.re && np < 4) begin
        pops[np] = c;
        np++;
      end
      if (done_a && nd < 4) begin
        dones[nd] = c;
        nd++;
      end
      for (int j = 0; j < np; j++)
        if (c == pops[j] + 46) par[j] = tx_a;
    end
    chk("t3_npops", 16'(np), 16'd3);
    if (np == 3 && nd >= 2) begin
      chk("t3_gap01", 16'(pops[1] - pops[0]), 16'd52);
      chk("t3_gap12", 16'(pops[2] - pops[1]), 16'd52);
      chk("t3_pop_done1", 16'(pops[1] - dones[0]), 16'd0);
      chk("t3_pop_done2", 16'(pops[2] - dones[1]), 16'd0);
      chk("t3_par0", 16'(par[0]), 16'd1);
      chk("t3_par1", 16'(par[1]), 16'd0);
      chk("t3_par2", 16'(par[2]), 16'd1);
    end
    chk("t3_frames", fs_a, 16'd4);

    // 4: enable drops mid-DATA with two words queued
    drv();
    push(0, 10'h0AA);
    push(0, 10'h155);
    wait_re(0, 10);
    repeat (20) tick();
    drv();
    enable = 1'b0;
    cnt_re = 0;
    cnt_d  = 0;
    repeat (120) begin
      tick();
      if (ifa.re) cnt_re++;
      if (done_a) cnt_d++;
    end
    chk("t4_no_pop", 16'(cnt_re), 16'd0);
    chk("t4_done", 16'(cnt_d), 16'd1);
    chk("t4_fill", 16'(npush0 - npop0), 16'd1);
    drv();
    enable = 1'b1;
    tick();
    chk("t4_resume_pop", 16'(ifa.re), 16'd1);
    repeat (60) tick();
    chk("t4_frames", fs_a, 16'd6);

    // 5: reset mid-DATA
    drv();
    push(0, 10'h0F0);
    wait_re(0, 10);
    repeat (20) tick();
    drv();
    rst = 1'b1;
    #1;
    chk("t5_async_tx", 16'(tx_a), 16'd1);
    chk("t5_async_busy", 16'(busy_a), 16'd0);
    chk("t5_async_frames", fs_a, 16'd0);
    repeat (3) tick();
    drv();
    rst = 1'b0;
    cnt_re = 0;
    cnt_x  = 0;
    repeat (30) begin
      tick();
      if (ifa.re) cnt_re++;
      if (busy_a || !tx_a) cnt_x++;
    end
    chk("t5_no_pop", 16'(cnt_re), 16'd0);
    chk("t5_idle", 16'(cnt_x), 16'd0);

    // 6: odd parity, two stop bits, word 000
    drv();
    push(1, 10'h000);
    wait_re(1, 10);
    stop_hi = 0;
    for (int c = 1; c <= 56; c++) begin
      tick();
      if (c == 2) chk("t6_start", 16'(tx_b), 16'd0);
      if (c == 46) chk("t6_parity", 16'(tx_b), 16'd1);
      if (c >= 49 && tx_b) stop_hi++;
      if (c == 52) chk("t6_done_early", 16'(done_b), 16'd0);
      if (c == 56) chk("t6_done", 16'(done_b), 16'd1);
    end
    chk("t6_stop_len", 16'(stop_hi), 16'd8);
    tick();
    chk("t6_frames", fs_b, 16'd1);
    chk("t6_idle", 16'(busy_b), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/pkt_serial_tx.md
Name: pkt_serial_tx

Overview:
Downstream drain stage for the 16-deep 10-bit packet FIFO. Pops one 10-bit packet at a time through the FIFO's re/empty interface and transmits it on a single-wire asynchronous serial line. Frame format: start bit, 10 data bits LSB first, optional parity bit, then stop bit(s). Sits between the packet FIFO and the chip-level serial pad.

Parameters:
CLKS_PER_BIT, 16, clk cycles per serial bit; legal range >= 2
PARITY_EN, 1, 1 = insert parity bit after data, 0 = no parity bit
PARITY_ODD, 0, 0 = even parity, 1 = odd parity; ignored when PARITY_EN=0
STOP_BITS, 1, number of stop bits; legal values 1 or 2

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  asynchronous, active-high reset
enable  input  1  permits starting new frames; never aborts a frame in progress
fifo_data  input  10  FIFO head word; valid combinationally whenever fifo_empty=0
fifo_empty  input  1  FIFO empty flag
fifo_re  output  1  pop strobe to FIFO; one cycle per packet
tx  output  1  serial line; idles high
busy  output  1  high from the cycle after pop until the end of the last stop bit
frame_done  output  1  single-cycle pulse in the last cycle of the last stop bit
frames_sent  output  16  count of completed frames; wraps 16'hFFFF -> 0

Behaviour:
- Reset (asynchronous):
  - tx=1, busy=0, frame_done=0, frames_sent=0, fifo_re=0.
  - State goes to IDLE; bit and baud counters clear; shift register clears.
- Reset mid-frame: the frame is abandoned. No further pop occurs, and the popped word is lost.
- Sequencer states: IDLE, START, DATA, PARITY, STOP. Each bit state lasts exactly CLKS_PER_BIT cycles, timed by a baud counter that reloads on every state or bit change.
- IDLE:
  - tx=1.
  - If enable=1 and fifo_empty=0: fifo_re=1 combinationally in that cycle; fifo_data latches into the shift register on that edge; next state is START.
- fifo_re is never asserted while fifo_empty=1. The FIFO has no underflow guard, so this rule is mandatory.
- START: tx=0. DATA drives bits 0..9 in order, LSB first. A 4-bit bit counter runs 0..9.
- PARITY (only when PARITY_EN=1):
  - tx = XOR of all 10 data bits, inverted when PARITY_ODD=1.
  - The parity value is computed from the latched word, not from live fifo_data.
- STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles.
- Last cycle of STOP:
  - frame_done=1 and frames_sent increments.
  - If enable=1 and fifo_empty=0, fifo_re=1 in this same cycle, the next word latches, and the next state is START. Back-to-back frames therefore have zero idle gap.
  - Otherwise the next state is IDLE.
- Frame length is (1 + 10 + PARITY_EN + STOP_BITS) * CLKS_PER_BIT cycles; defaults give 208.
- Latency: tx falls on the first cycle after the pop edge.
- enable dropping mid-frame: the current frame completes normally, and no new pop occurs until enable=1 again.
- fifo_empty or fifo_data changing mid-frame has no effect, because the word is already latched.
- busy=0 only in IDLE.
- tx is driven from a flop so the line is glitch-free.

Decomposition:
- Shared package pkt_pkg holds:
  - localparam PKT_W=10;
  - typedef enum logic [2:0] tx_state_t {IDLE, START, DATA, PARITY, STOP};
  - typedef logic [PKT_W-1:0] pkt_t.
  The same package is reused by the FIFO and by future upstream stages.
- One sub-module, pkt_baud_gen: parameter CLKS_PER_BIT; inputs clk, rst, restart; output bit_end, which pulses in the last cycle of each bit period.

Test Plan:
1. CLKS_PER_BIT=4, even parity, 1 stop; push 10'h2A5 into an empty FIFO, enable=1 -> one fifo_re pulse, then tx = 0, 1,0,1,0,0,1,0,1,0,1, parity 1, stop 1, each bit 4 cycles; frame_done at cycle 52 after the pop; frames_sent=1.
2. FIFO empty, enable=1 for 200 cycles -> fifo_re never asserted, tx=1, busy=0.
3. Three words 10'h001, 10'h3FF, 10'h155 queued -> exactly 3 fifo_re pulses, each coincident with frame_done of the prior frame; frames spaced exactly 52 cycles with no idle gap; parity bits 1, 0, 1 (even).
4. enable deasserted mid-DATA with 2 words queued -> current frame completes, no further fifo_re, FIFO still holds 1 word; re-enable -> the next frame starts with a pop in the following cycle.
5. rst asserted mid-DATA -> tx=1 and busy=0 immediately (asynchronous), frames_sent=0; after release with the FIFO empty, the line stays idle.
6. PARITY_ODD=1, STOP_BITS=2; send 10'h000 -> parity bit 1; stop high for 8 cycles; frame length 56 cycles.
